// File: rtl/bd_chunk_serializer.sv
// BD funnel word serializer: splits each leaf word into NDATA_OUT-bit
// chunks, low bits first, with per-leaf masking and a last-chunk flag.
module bd_chunk_serializer #(
    parameter int NCODE     = 8,
    parameter int NPAYLOAD  = 32,
    parameter int NDATA_OUT = 24,
    parameter int NLEAF     = 13,
    parameter int WIDTH_USED [NLEAF] =
        '{19, 8, 20, 19, 19, 20, 29, 29, 12, 1, 1, 28, 32}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_in_v,
    output logic                 dec_in_a,
    input  logic [NCODE-1:0]     dec_in_leaf_code,
    input  logic [NPAYLOAD-1:0]  dec_in_payload,
    output logic                 ser_out_v,
    input  logic                 ser_out_a,
    output logic [NCODE-1:0]     ser_out_code,
    output logic [NDATA_OUT-1:0] ser_out_payload,
    output logic                 ser_out_last,
    output logic                 err_bad_code
);

    localparam int MAX_CHUNKS = (NPAYLOAD + NDATA_OUT - 1) / NDATA_OUT;
    localparam int KW         = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam int PADW       = MAX_CHUNKS * NDATA_OUT;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [NPAYLOAD-1:0]   r_held;
    logic [KW-1:0]         r_k;
    logic [KW-1:0]         r_last_k;
    logic [NCODE-1:0]      r_code;
    logic [NDATA_OUT-1:0]  r_payload;
    logic                  r_last;
    logic                  r_err;

    logic                  w_capture;
    logic                  w_advance;
    logic                  w_known;
    int                    w_width;
    int                    w_nch;
    logic [KW-1:0]         w_last_k;
    logic [NPAYLOAD-1:0]   w_mask;
    logic [NPAYLOAD-1:0]   w_in_masked;
    logic [PADW-1:0]       w_in_pad;
    logic [PADW-1:0]       w_held_pad;
    logic [KW-1:0]         w_knext;
    logic [NDATA_OUT-1:0]  w_next_chunk;

    // Leaf table lookup: used width, chunk count and payload mask
    always_comb begin
        w_width = NPAYLOAD;
        w_known = 1'b0;
        for (int i = 0; i < NLEAF; i++) begin
            if (dec_in_leaf_code == NCODE'(i)) begin
                w_width = WIDTH_USED[i];
                w_known = 1'b1;
            end
        end
        w_nch = (w_width + NDATA_OUT - 1) / NDATA_OUT;
        if (w_nch < 1 || !w_known) begin
            w_nch = 1;
        end
        w_last_k = KW'(w_nch - 1);
        for (int b = 0; b < NPAYLOAD; b++) begin
            w_mask[b] = (b < w_width);
        end
        w_in_masked = dec_in_payload & w_mask;
        w_in_pad = '0;
        w_in_pad[NPAYLOAD-1:0] = w_in_masked;
    end

    // Select the chunk that follows the one currently presented
    always_comb begin
        w_held_pad = '0;
        w_held_pad[NPAYLOAD-1:0] = r_held;
        w_knext = r_k + 1'b1;
        w_next_chunk = '0;
        for (int c = 0; c < MAX_CHUNKS; c++) begin
            if (w_knext == KW'(c)) begin
                w_next_chunk = w_held_pad[c*NDATA_OUT +: NDATA_OUT];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state, input accept and datapath load strobes
    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
        w_advance = 1'b0;
        dec_in_a  = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_IDLE: begin
                    dec_in_a = 1'b1;
                    if (dec_in_v) begin
                        w_capture = 1'b1;
                        w_state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (ser_out_a) begin
                        if (!r_last) begin
                            w_advance = 1'b1;
                        end else begin
                            dec_in_a = 1'b1;
                            if (dec_in_v) begin
                                w_capture = 1'b1;
                            end else begin
                                w_state_d = S_IDLE;
                            end
                        end
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    // Word capture, chunk stepping and sticky bad-code flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_held    <= '0;
            r_k       <= '0;
            r_last_k  <= '0;
            r_code    <= '0;
            r_payload <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_capture) begin
            r_held    <= w_in_masked;
            r_k       <= '0;
            r_last_k  <= w_last_k;
            r_code    <= dec_in_leaf_code;
            r_payload <= w_in_pad[NDATA_OUT-1:0];
            r_last    <= (w_nch == 1);
            if (!w_known) begin
                r_err <= 1'b1;
            end
        end else if (w_advance) begin
            r_k       <= w_knext;
            r_payload <= w_next_chunk;
            r_last    <= (w_knext == r_last_k);
        end
    end

    assign ser_out_v       = (r_state == S_SEND);
    assign ser_out_code    = r_code;
    assign ser_out_payload = r_payload;
    assign ser_out_last    = r_last;
    assign err_bad_code    = r_err;

endmodule

// File: tb/tb_bd_chunk_serializer.sv
// Bench for bd_chunk_serializer: scoreboard of expected chunks popped by
// a monitor on every output handshake, plus an 8-bit-chunk instance.
module tb_bd_chunk_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_in_v = 1'b0;
    logic        dec_in_a;
    logic [7:0]  dec_in_leaf_code = '0;
    logic [31:0] dec_in_payload = '0;
    logic        ser_out_v;
    logic        ser_out_a = 1'b1;
    logic [7:0]  ser_out_code;
    logic [23:0] ser_out_payload;
    logic        ser_out_last;
    logic        err_bad_code;

    logic        d8_v = 1'b0;
    logic        d8_in_a;
    logic [7:0]  d8_code = '0;
    logic [31:0] d8_pay = '0;
    logic        d8_ov;
    logic [7:0]  d8_ocode;
    logic [7:0]  d8_opay;
    logic        d8_olast;
    logic        d8_err;

    typedef struct {
        logic [7:0]  code;
        logic [23:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    bit   stall_mode = 1'b0;

    logic        p_v = 1'b0;
    logic        p_a = 1'b0;
    logic        p_rst = 1'b1;
    logic [32:0] p_bus = '0;

    bd_chunk_serializer u_dut (
        .clk(clk), .reset(reset),
        .dec_in_v(dec_in_v), .dec_in_a(dec_in_a),
        .dec_in_leaf_code(dec_in_leaf_code),
        .dec_in_payload(dec_in_payload),
        .ser_out_v(ser_out_v), .ser_out_a(ser_out_a),
        .ser_out_code(ser_out_code),
        .ser_out_payload(ser_out_payload),
        .ser_out_last(ser_out_last),
        .err_bad_code(err_bad_code)
    );

    bd_chunk_serializer #(.NDATA_OUT(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .dec_in_v(d8_v), .dec_in_a(d8_in_a),
        .dec_in_leaf_code(d8_code),
        .dec_in_payload(d8_pay),
        .ser_out_v(d8_ov), .ser_out_a(1'b1),
        .ser_out_code(d8_ocode),
        .ser_out_payload(d8_opay),
        .ser_out_last(d8_olast),
        .err_bad_code(d8_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic [23:0] d,
                        input logic l);
        exp_t e;
        e.code = c;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Enter at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_word(input logic [7:0] c, input logic [31:0] p,
                             output int waited);
        bit done;
        done = 1'b0;
        waited = 0;
        dec_in_v = 1'b1;
        dec_in_leaf_code = c;
        dec_in_payload = p;
        while (!done && waited < 200) begin
            @(negedge clk);
            if (dec_in_a) begin
                done = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        dec_in_v = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Sink ready: always high, or high 70% of cycles when stalling
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) ser_out_a = ($urandom_range(0, 99) >= 30);
            else ser_out_a = 1'b1;
        end
    end

    // Monitor: pop and compare on each handshake; check hold while stalled
    always @(negedge clk) begin
        exp_t e;
        logic [32:0] bus;
        bus = {ser_out_code, ser_out_payload, ser_out_last};
        if (!reset && !p_rst && p_v && !p_a)
            check("stall_hold", {ser_out_v, bus}, {1'b1, p_bus});
        if (!reset && ser_out_v && ser_out_a) begin
            if (exp_q.size() == 0) begin
                check("extra_chunk", {31'd0, bus}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("chunk", {31'd0, bus}, {31'd0, e.code, e.data, e.last});
            end
        end
        p_v = ser_out_v;
        p_a = ser_out_a;
        p_rst = reset;
        p_bus = bus;
    end

    logic [31:0] w5 [6] = '{32'hDEADBEEF, 32'h01234567, 32'hFFFFFFFF,
                            32'h80000001, 32'h00000000, 32'hA5C3F00F};
    logic [31:0] p4 [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678,
                            32'hAAAAAAAA, 32'h00080000};
    logic [23:0] e4 [5] = '{24'h000001, 24'h07FFFF, 24'h045678,
                            24'h02AAAA, 24'h000000};
    logic [7:0]  e8 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        int w;
        bit got;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_v", 64'(ser_out_v), 64'd0);
        check("rst_a", 64'(dec_in_a), 64'd0);
        check("rst_err", 64'(err_bad_code), 64'd0);
        check("rst_pay", {31'd0, ser_out_code, ser_out_payload, ser_out_last},
              64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_a", 64'(dec_in_a), 64'd1);

        // Leaf 12 split into two chunks
        push(8'd12, 24'hADBEEF, 1'b0);
        push(8'd12, 24'h0000DE, 1'b1);
        send_word(8'd12, 32'hDEADBEEF, w);
        @(negedge clk);
        check("t2_a_chunk0", 64'(dec_in_a), 64'd0);
        @(negedge clk);
        check("t2_a_chunk1", 64'(dec_in_a), 64'd1);
        @(posedge clk);
        #1;
        drain("t2_drain");

        // Masking of narrow leaves
        push(8'd9, 24'h000001, 1'b1);
        send_word(8'd9, 32'hFFFFFFFF, w);
        push(8'd1, 24'h000078, 1'b1);
        send_word(8'd1, 32'h12345678, w);
        drain("t3_drain");

        // Back-to-back single-chunk words
        for (int i = 0; i < 5; i++) begin
            push(8'd3, e4[i], 1'b1);
            send_word(8'd3, p4[i], w);
            check("t4_no_wait", 64'(w), 64'd0);
        end
        drain("t4_drain");

        // Leaf 12 words under random sink stall
        stall_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(8'd12, w5[i][23:0], 1'b0);
            push(8'd12, {16'd0, w5[i][31:24]}, 1'b1);
            send_word(8'd12, w5[i], w);
        end
        drain("t5_drain");
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Unknown leaf code
        check("t6_err_before", 64'(err_bad_code), 64'd0);
        push(8'd13, 24'hABCDEF, 1'b1);
        send_word(8'd13, 32'h00ABCDEF, w);
        drain("t6_drain");
        check("t6_err_set", 64'(err_bad_code), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_sticky", 64'(err_bad_code), 64'd1);

        // Reset mid-word: only chunk 0 may appear
        push(8'd12, 24'h223344, 1'b0);
        send_word(8'd12, 32'h11223344, w);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t1_a_in_rst", 64'(dec_in_a), 64'd0);
        @(posedge clk);
        #1;
        check("t1_v", 64'(ser_out_v), 64'd0);
        check("t1_err", 64'(err_bad_code), 64'd0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t1_queue", 64'(exp_q.size()), 64'd0);

        // 8-bit chunk instance, leaf 12
        d8_v = 1'b1;
        d8_code = 8'd12;
        d8_pay = 32'hDEADBEEF;
        @(negedge clk);
        check("w8_accept", 64'(d8_in_a), 64'd1);
        @(posedge clk);
        #1;
        d8_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if (d8_ov) got = 1'b1;
            end
            if (!got) check("w8_timeout", 64'd0, 64'd1);
            else check("w8_chunk", {47'd0, d8_ocode, d8_opay, d8_olast},
                       {47'd0, 8'd12, e8[k], (k == 3)});
        end
        @(negedge clk);
        check("w8_idle", 64'(d8_ov), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
